// File: rtl/prg_loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and
// parameter defaults used by the loader and its idle timer.
package prg_loader_pkg;

  localparam int unsigned MAX_WORDS_DEFAULT   = 16384;
  localparam int unsigned TIMEOUT_CYC_DEFAULT = 1_000_000;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/prg_loader_timer.sv
// Idle-gap timer for the program loader: counts enabled cycles since the
// last clear and flags expiry once TIMEOUT_CYC idle cycles have elapsed.
module prg_loader_timer
  import prg_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned    CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + CW'(1);
    end
  end

  // Asserted during the idle cycle whose closing edge is the TIMEOUT_CYC-th
  // since the last clear, so the owner reacts on exactly that edge.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/prg_loader.sv
// Boot-time program loader: receives a length-prefixed little-endian image
// over a byte stream and writes it word by word into instruction RAM.
module prg_loader
  import prg_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT,
  parameter int unsigned MAX_WORDS   = MAX_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        ram_we,
  output logic [13:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  state_t      state, state_nx;
  logic [14:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [15:0] n_words;
  logic [31:0] word_buf;

  logic        accept;
  logic [15:0] n_full;
  logic        hdr_bad;
  logic        last_word;
  logic        tmr_en;
  logic        tmr_clear;
  logic        tmr_expired;

  assign rx_ready  = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign accept    = rx_valid && rx_ready;
  assign n_full    = {rx_data, n_words[7:0]};
  assign hdr_bad   = (n_full == '0) || ({1'b0, n_full} > MAX_N);
  assign last_word = (({1'b0, word_idx}) + 16'd1) == n_words;

  // HDR0 is left on its first accepted byte, so counting only in HDR1/DATA
  // means waiting for the header can never time out.
  assign tmr_en    = ((state == HDR1) || (state == DATA)) && !accept;
  assign tmr_clear = !tmr_en;

  assign ram_addr  = word_idx[13:0];
  assign ram_wdata = word_buf;

  prg_loader_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_en),
    .expired(tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx <= '0;
      byte_cnt <= '0;
      n_words  <= '0;
      word_buf <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        HDR0: if (accept) n_words[7:0]  <= rx_data;
        HDR1: if (accept) n_words[15:8] <= rx_data;
        DATA: begin
          if (accept) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= rx_data;
            byte_cnt                          <= byte_cnt + 2'd1;
          end
        end
        WRITE:   word_idx <= word_idx + 15'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    ram_we   = 1'b0;
    cpu_hold = 1'b1;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      IDLE: begin
        cpu_hold = 1'b0;
        if (start) state_nx = HDR0;
      end
      HDR0: begin
        busy = 1'b1;
        if (accept) state_nx = HDR1;
      end
      HDR1: begin
        busy = 1'b1;
        if (accept)           state_nx = hdr_bad ? ERR : DATA;
        else if (tmr_expired) state_nx = ERR;
      end
      DATA: begin
        busy = 1'b1;
        if (accept && (byte_cnt == 2'd3)) state_nx = WRITE;
        else if (tmr_expired)             state_nx = ERR;
      end
      WRITE: begin
        busy     = 1'b1;
        ram_we   = 1'b1;
        state_nx = last_word ? DONE : DATA;
      end
      DONE: begin
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) state_nx = HDR0;
      end
      ERR: begin
        err = 1'b1;
        if (start) state_nx = HDR0;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prg_loader.sv
// Self-checking bench for prg_loader: cycle-accurate vector table for a
// two-word load, then directed sequences for header errors, timeout and reset.
module tb_prg_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        ram_we;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [0:15];
  int          wr_count = 0;

  prg_loader #(
    .TIMEOUT_CYC(100),
    .MAX_WORDS  (16384)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // RAM model captured mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (ram_we) begin
      mem[ram_addr[3:0]] = ram_wdata;
      wr_count++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [7:0]  data;
    logic [5:0]  exp;    // {rx_ready, ram_we, cpu_hold, busy, done, err}
    logic [13:0] addr;
    logic [31:0] wdata;
  } vec_t;

  vec_t vt [15];

  function automatic logic [5:0] outs();
    return {rx_ready, ram_we, cpu_hold, busy, done, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int k;
    rx_valid = 1'b1;
    rx_data  = b;
    k = 0;
    while (!rx_ready && k < 50) begin
      step();
      k++;
    end
    if (k >= 50) chk("send_byte_ready_timeout", 32'(k), 32'd0);
    step();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    int cyc;

    vt[0]  = '{1'b1, 1'b0, 8'h00, 6'b000000, 14'd0, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 8'h02, 6'b101100, 14'd0, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 8'h00, 6'b101100, 14'd0, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 8'h13, 6'b101100, 14'd0, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 8'h00, 6'b101100, 14'd0, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 8'h00, 6'b101100, 14'd0, 32'h0};
    vt[6]  = '{1'b0, 1'b1, 8'h00, 6'b101100, 14'd0, 32'h0};
    vt[7]  = '{1'b0, 1'b1, 8'h37, 6'b011100, 14'd0, 32'h00000013};
    vt[8]  = '{1'b0, 1'b1, 8'h37, 6'b101100, 14'd0, 32'h0};
    vt[9]  = '{1'b0, 1'b1, 8'h12, 6'b101100, 14'd0, 32'h0};
    vt[10] = '{1'b0, 1'b1, 8'h34, 6'b101100, 14'd0, 32'h0};
    vt[11] = '{1'b0, 1'b1, 8'h00, 6'b101100, 14'd0, 32'h0};
    vt[12] = '{1'b0, 1'b0, 8'h00, 6'b011100, 14'd1, 32'h00341237};
    vt[13] = '{1'b0, 1'b0, 8'h00, 6'b000010, 14'd0, 32'h0};
    vt[14] = '{1'b0, 1'b0, 8'h00, 6'b000010, 14'd0, 32'h0};

    // reset state
    step();
    step();
    chk("outs_in_reset", 32'(outs()), 32'd0);
    reset = 1'b0;
    step();
    chk("outs_after_reset", 32'(outs()), 32'd0);

    // two-word load with rx_valid held high across WRITE
    for (int i = 0; i < 15; i++) begin
      start    = vt[i].start;
      rx_valid = vt[i].valid;
      rx_data  = vt[i].data;
      #1;
      chk($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vt[i].exp));
      if (vt[i].exp[4]) begin
        chk($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vt[i].addr));
        chk($sformatf("vec%0d_wdata", i), ram_wdata, vt[i].wdata);
      end
      step();
    end
    chk("load2_mem0", mem[0], 32'h00000013);
    chk("load2_mem1", mem[1], 32'h00341237);
    chk("load2_wr_count", 32'(wr_count), 32'd2);

    // header wait never times out; N=0 header aborts
    pulse_start();
    for (int i = 0; i < 300; i++) step();
    chk("hdr_wait_busy_err", {30'd0, busy, err}, {30'd0, 1'b1, 1'b0});
    send_byte(8'h00);
    send_byte(8'h00);
    chk("n0_outs", 32'(outs()), 32'(6'b001001));
    for (int i = 0; i < 20; i++) step();
    chk("n0_hold_stays", 32'(outs()), 32'(6'b001001));
    chk("n0_no_write", 32'(wr_count), 32'd2);
    pulse_start();
    chk("restart_clears_err", 32'(outs()), 32'(6'b101100));

    // N=16641 exceeds capacity
    send_byte(8'h01);
    send_byte(8'h41);
    chk("nbig_outs", 32'(outs()), 32'(6'b001001));
    chk("nbig_no_write", 32'(wr_count), 32'd2);

    // timeout after partial word
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    cyc = 0;
    while (!err && cyc < 300) begin
      step();
      cyc++;
    end
    chk("timeout_cycles", 32'(cyc), 32'd100);
    chk("timeout_no_write", 32'(wr_count), 32'd2);

    // reset wins over start in the same cycle
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    chk("reset_over_start", 32'(outs()), 32'd0);
    step();
    chk("reset_over_start_idle", 32'(outs()), 32'd0);

    // reset mid-load after first write
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(32'h11223344);
    cyc = 0;
    while (wr_count < 3 && cyc < 10) begin
      step();
      cyc++;
    end
    send_byte(8'h55);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midload_reset_outs", 32'(outs()), 32'd0);
    for (int i = 0; i < 5; i++) step();
    chk("midload_reset_wr_count", 32'(wr_count), 32'd3);
    chk("midload_mem0", mem[0], 32'h11223344);

    // fresh 3-word load, with start pulsed mid-load (ignored)
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(32'hAABBCCDD);
    start = 1'b1;
    send_word(32'h01020304);
    start = 1'b0;
    send_word(32'hDEADBEEF);
    cyc = 0;
    while (!done && cyc < 10) begin
      step();
      cyc++;
    end
    chk("load3_outs", 32'(outs()), 32'(6'b000010));
    chk("load3_mem0", mem[0], 32'hAABBCCDD);
    chk("load3_mem1", mem[1], 32'h01020304);
    chk("load3_mem2", mem[2], 32'hDEADBEEF);
    chk("load3_wr_count", 32'(wr_count), 32'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
